pending_or_aggregator: RTL and testbench

- Parametrised, clocked successor of the fixed 12-input bubbled OR gate.
- Reduces NrOfInputs request lines, each with an optional per-input bubble (inversion), into sticky pending bits. Outputs a registered OR, a combinational OR, and the lowest-index pending request.
- Used in the redirection pipeline to collect hazard, redirect and BTB-miss requests.
- Pending requests are cleared by the consumer through a clear/acknowledge handshake.

---
 rtl/pending_or_aggregator.sv | 178 +++++++++++++++++
 tb/tb_pending_or_aggregator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pending_or_aggregator.sv
// -----------------------------------------------------------------------------
// pending_or_aggregator
//
// Purpose:
//   Clocked, parametrised successor of the fixed 12-input bubbled OR gate.
//   Each raw request line can be inverted by a bubble before use and masked
//   by a per-input enable. The surviving requests are collected into sticky
//   pending bits, which the consumer clears through a clear/acknowledge
//   handshake. The block is used in the redirection pipeline to gather hazard,
//   redirect and BTB-miss requests.
//
// Optional build macro:
//   PENDING_OR_AGGREGATOR_EDGE_EN - when defined, only rising edges of the
//   bubbled inputs set pending bits and count events. A registered copy of
//   the bubbled inputs is built for this. Result_Comb stays level based.
//   When undefined, requests are level sensitive and that register is absent.
//
// Parameters:
//   NrOfInputs  - number of request lines (1..32)
//   BubblesMask - bit i = 1 inverts Inputs[i] before use
//   IndexWidth  - width of First_Index, at least max(1, clog2(NrOfInputs))
//   CountWidth  - width of the saturating event counter
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Inputs       in   raw request lines
//   Enable_Wr    in   load Enable_Data into the enable register
//   Enable_Data  in   new per-input enable mask
//   Clear_Valid  in   clear request
//   Clear_Mask   in   pending bits to clear
//   Clear_Ack    out  one-cycle acknowledge of an accepted clear
//   Pending      out  sticky pending register
//   Result       out  registered OR of Pending
//   Result_Comb  out  combinational OR of enabled, bubbled inputs
//   First_Index  out  lowest set index of Pending (0 when Pending is zero)
//   First_Valid  out  Pending is non-zero
//   Event_Count  out  saturating count of newly set pending bits
// -----------------------------------------------------------------------------
module pending_or_aggregator #(
   parameter int unsigned           NrOfInputs  = 12,
   parameter logic [NrOfInputs-1:0] BubblesMask = '0,
   parameter int unsigned           IndexWidth  = 4,
   parameter int unsigned           CountWidth  = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [NrOfInputs-1:0] Inputs,
   input  logic                  Enable_Wr,
   input  logic [NrOfInputs-1:0] Enable_Data,
   input  logic                  Clear_Valid,
   input  logic [NrOfInputs-1:0] Clear_Mask,
   output logic                  Clear_Ack,
   output logic [NrOfInputs-1:0] Pending,
   output logic                  Result,
   output logic                  Result_Comb,
   output logic [IndexWidth-1:0] First_Index,
   output logic                  First_Valid,
   output logic [CountWidth-1:0] Event_Count
);

   // Popcount of up to 32 bits needs 6 bits; the sum is widened so the
   // saturation compare never overflows.
   localparam int unsigned PopWidth = 6;
   localparam int unsigned SumWidth = CountWidth + PopWidth;

   logic [NrOfInputs-1:0] enable_q;
   logic [NrOfInputs-1:0] pending_q;
   logic                  result_q;
   logic                  clear_ack_q;
   logic [CountWidth-1:0] event_count_q;

   logic [NrOfInputs-1:0] real_in;
   logic [NrOfInputs-1:0] req;
   logic [NrOfInputs-1:0] clr;
   logic [NrOfInputs-1:0] pending_next;
   logic [NrOfInputs-1:0] new_bits;
   logic [PopWidth-1:0]   new_count;
   logic [SumWidth-1:0]   count_sum;
   logic [CountWidth-1:0] count_next;
   logic [IndexWidth-1:0] first_index;

   // Bubbles are applied first; everything downstream sees the true sense.
   assign real_in = Inputs ^ BubblesMask;

   // The combinational OR is always level based so it keeps the old gate's
   // function when every input is enabled.
   assign Result_Comb = |(real_in & enable_q);

`ifdef PENDING_OR_AGGREGATOR_EDGE_EN
   logic [NrOfInputs-1:0] real_in_q;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         real_in_q <= '0;
      end else begin
         real_in_q <= real_in;
      end
   end

   // Only a 0->1 transition of the bubbled input raises a request.
   assign req = real_in & ~real_in_q & enable_q;
`else
   assign req = real_in & enable_q;
`endif

   // Clear handshake: a clear is accepted in every cycle Clear_Valid is high
   // (there is no back-pressure, so no ready signal exists). Clear_Ack is high
   // exactly in the following cycle, so back-to-back clears give back-to-back
   // acks. A zero Clear_Mask is still acknowledged and clears nothing.
   assign clr = Clear_Valid ? Clear_Mask : '0;

   // Set is ORed in after the clear so a request arriving in the clear cycle
   // is never lost.
   assign pending_next = (pending_q & ~clr) | req;

   // Only bits that go from clear to set count as events; a request that is
   // held against an already pending bit does not count again.
   assign new_bits = req & ~pending_q;

   always_comb begin
      new_count = '0;
      for (int i = 0; i < int'(NrOfInputs); i++) begin
         new_count = new_count + PopWidth'(new_bits[i]);
      end
   end

   always_comb begin
      count_sum  = SumWidth'(event_count_q) + SumWidth'(new_count);
      count_next = count_sum[CountWidth-1:0];
      if (count_sum > SumWidth'({CountWidth{1'b1}})) begin
         count_next = {CountWidth{1'b1}};
      end
   end

   // Priority encoder, lowest index wins: scanning from the top down lets the
   // last hit (the lowest set bit) stick. With one input this is always 0.
   always_comb begin
      first_index = '0;
      for (int i = int'(NrOfInputs) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            first_index = IndexWidth'(i);
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         enable_q <= '1;
      end else if (Enable_Wr) begin
         enable_q <= Enable_Data;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pending_q     <= '0;
         result_q      <= 1'b0;
         clear_ack_q   <= 1'b0;
         event_count_q <= '0;
      end else begin
         pending_q     <= pending_next;
         // Registered from the current pending value, so Result trails
         // Pending by one cycle.
         result_q      <= |pending_q;
         clear_ack_q   <= Clear_Valid;
         event_count_q <= count_next;
      end
   end

   assign Pending     = pending_q;
   assign Result      = result_q;
   assign Clear_Ack   = clear_ack_q;
   assign Event_Count = event_count_q;
   assign First_Index = first_index;
   assign First_Valid = |pending_q;

endmodule

// File: tb/tb_pending_or_aggregator.sv
module tb_pending_or_aggregator;

   localparam int N = 12;
   localparam int W = 27;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance: default parameters
   logic [N-1:0] inputs, en_data, clr_mask;
   logic         en_wr, clr_valid;
   logic         clear_ack, result, result_comb, first_valid;
   logic [N-1:0] pending;
   logic [3:0]   first_index;
   logic [7:0]   event_count;

   // second instance: bit 0 bubbled, 2-bit counter
   logic [N-1:0] b_inputs, b_en_data, b_clr_mask;
   logic         b_en_wr, b_clr_valid;
   logic         b_clear_ack, b_result, b_result_comb, b_first_valid;
   logic [N-1:0] b_pending;
   logic [3:0]   b_first_index;
   logic [1:0]   b_event_count;

   pending_or_aggregator dut (
      .Clock(clk), .Reset(rst), .Inputs(inputs),
      .Enable_Wr(en_wr), .Enable_Data(en_data),
      .Clear_Valid(clr_valid), .Clear_Mask(clr_mask), .Clear_Ack(clear_ack),
      .Pending(pending), .Result(result), .Result_Comb(result_comb),
      .First_Index(first_index), .First_Valid(first_valid),
      .Event_Count(event_count)
   );

   pending_or_aggregator #(
      .NrOfInputs(12), .BubblesMask(12'h001), .IndexWidth(4), .CountWidth(2)
   ) dut_b (
      .Clock(clk), .Reset(rst), .Inputs(b_inputs),
      .Enable_Wr(b_en_wr), .Enable_Data(b_en_data),
      .Clear_Valid(b_clr_valid), .Clear_Mask(b_clr_mask), .Clear_Ack(b_clear_ack),
      .Pending(b_pending), .Result(b_result), .Result_Comb(b_result_comb),
      .First_Index(b_first_index), .First_Valid(b_first_valid),
      .Event_Count(b_event_count)
   );

   // ---------------- scoreboard ----------------
   int err_cnt = 0;
   int chk_cnt = 0;
   logic [W-1:0] exp_q[$];

   // reference state of the main instance
   logic [N-1:0] m_pending, m_enable, m_real_q;
   logic         m_result, m_ack;
   logic [7:0]   m_count;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] lowest(input logic [N-1:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   task automatic model_reset();
      m_pending = '0;
      m_enable  = '1;
      m_real_q  = '0;
      m_result  = 1'b0;
      m_ack     = 1'b0;
      m_count   = '0;
      exp_q.delete();
   endtask

   // Drives one cycle of stimulus (entered and left at a falling edge),
   // pushes the expected post-edge state, then pops and compares it.
   task automatic step(input logic [N-1:0] in, input logic ew, input logic [N-1:0] ed,
                       input logic cv, input logic [N-1:0] cm, input logic [N-1:0] b_in);
      logic [N-1:0] req, clr;
      logic [8:0]   sum;
      logic [W-1:0] e;
      inputs = in; en_wr = ew; en_data = ed; clr_valid = cv; clr_mask = cm;
      b_inputs = b_in;
      #1;
      check("result_comb", result_comb, |(in & m_enable));
      req = in & m_enable;
`ifdef PENDING_OR_AGGREGATOR_EDGE_EN
      req = req & ~m_real_q;
`endif
      clr = cv ? cm : '0;
      sum = 9'(m_count) + 9'($countones(req & ~m_pending));
      if (sum > 9'd255) sum = 9'd255;
      m_result  = |m_pending;
      m_pending = (m_pending & ~clr) | req;
      m_ack     = cv;
      m_count   = sum[7:0];
      if (ew) m_enable = ed;
      m_real_q  = in;
      exp_q.push_back({m_pending, m_result, m_ack, m_count, |m_pending, lowest(m_pending)});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("sb_state", {pending, result, clear_ack, event_count, first_valid, first_index}, e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [N-1:0] b_in);
      step('0, 1'b0, '0, 1'b0, '0, b_in);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      inputs = '1; en_wr = 1'b0; en_data = '0; clr_valid = 1'b0; clr_mask = '0;
      b_inputs = '0; b_en_wr = 1'b0; b_en_data = '0; b_clr_valid = 1'b0; b_clr_mask = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_pending", pending, 0);
      check("rst_hold_count", event_count, 0);

      @(negedge clk);
      rst = 1'b0;
      inputs = '0;
      #1;
      check("rst_pending", pending, 0);
      check("rst_result", result, 0);
      check("rst_ack", clear_ack, 0);
      check("rst_count", event_count, 0);
      check("rst_first_valid", first_valid, 0);
      check("rst_first_index", first_index, 0);
      check("bub_comb", b_result_comb, 1);
      check("bub_pending0", b_pending, 0);

      // bubble on bit 0 of the second instance, then counter saturation
      idle('0);
      check("bub_pending1", b_pending, 12'h001);
      check("bub_result1", b_result, 0);
      check("bub_first_idx", b_first_index, 0);
      check("bub_first_valid", b_first_valid, 1);
      check("bub_count1", b_event_count, 1);
      idle('0);
      check("bub_result2", b_result, 1);
      for (int i = 0; i < 10; i++) begin
         idle(12'h004);
         if (i == 0) check("hold_first_count", b_event_count, 2);
      end
      check("hold_count", b_event_count, 2);
      check("hold_pending", b_pending, 12'h005);
      idle(12'h002);
      check("sat_count3", b_event_count, 3);
      idle(12'h008);
      check("sat_count4", b_event_count, 3);
      idle(12'h010);
      check("sat_count5", b_event_count, 3);
      check("sat_pending", b_pending, 12'h01F);
      idle('0);
      check("sat_hold", b_event_count, 3);

      // priority and clear on the main instance
      step(12'h220, 1'b0, '0, 1'b0, '0, '0);
      check("prio_pending", pending, 12'h220);
      check("prio_idx5", first_index, 5);
      idle('0);
      step('0, 1'b0, '0, 1'b1, 12'h020, '0);
      check("clr_pending", pending, 12'h200);
      check("clr_idx9", first_index, 9);
      check("clr_ack", clear_ack, 1);
      idle('0);
      check("clr_ack_once", clear_ack, 0);

      // set/clear collision on bit 3
      step(12'h008, 1'b0, '0, 1'b1, 12'h008, '0);
      check("coll_bit3", pending[3], 1);
      check("coll_ack", clear_ack, 1);
      idle('0);

      // back-to-back clears, first with an empty mask
      step('0, 1'b0, '0, 1'b1, '0, '0);
      check("b2b_ack1", clear_ack, 1);
      check("zero_mask_keeps", pending, 12'h208);
      step('0, 1'b0, '0, 1'b1, '1, '0);
      check("b2b_ack2", clear_ack, 1);
      idle('0);

      // enable masking; disabling keeps an existing pending bit
      step(12'h080, 1'b0, '0, 1'b0, '0, '0);
      step('0, 1'b1, 12'hF7E, 1'b0, '0, '0);
      step(12'h001, 1'b0, '0, 1'b0, '0, '0);
      check("en_bit0_blocked", pending[0], 0);
      check("en_comb_low", result_comb, 0);
      check("dis_keeps_bit7", pending[7], 1);
      step('0, 1'b1, '1, 1'b1, '1, '0);

      // randomized traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         logic [N-1:0] rin;
         rin = N'($urandom) & N'($urandom) & N'($urandom);
         step(rin, ($urandom_range(0, 15) == 0), N'($urandom) | N'($urandom),
              ($urandom_range(0, 3) == 0), N'($urandom), '0);
      end

      // reset in the middle of a clear: outstanding ack is dropped
      step(12'h041, 1'b0, '0, 1'b1, 12'h001, '0);
      rst = 1'b1;
      #1;
      check("mid_rst_ack", clear_ack, 0);
      check("mid_rst_pending", pending, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_count", event_count, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(12'hFFF, 1'b0, '0, 1'b0, '0, '0);
      step('0, 1'b0, '0, 1'b0, '0, '0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
